// File: rtl/dp_job_scheduler.sv
// Round-robin job scheduler that shares one (A-B)+(C-D) compute unit between two requesters.
// Each granted job clears the unit, streams four operands, waits for the result (with timeout) and returns it tagged.
module dp_job_scheduler #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [4*WIDTH-1:0] req0_ops,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [4*WIDTH-1:0] req1_ops,
    output logic               req1_ready,
    output logic               dp_reset,
    output logic               dp_capture,
    output logic [1:0]         dp_op,
    output logic [WIDTH-1:0]   dp_d_in,
    input  logic               dp_valid,
    input  logic [WIDTH:0]     dp_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH:0]     rsp_data,
    output logic               rsp_err,
    output logic               busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CLR, SEND, WAIT, RESP} state_t;

    state_t             state, state_nx;
    logic               last_grant;
    logic               id_q;
    logic [4*WIDTH-1:0] ops_q;
    logic [1:0]         cnt;
    logic [TW-1:0]      tcnt;
    logic [WIDTH:0]     data_q;
    logic               err_q;
    logic               grant0, grant1, timeout_hit;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant0      = req0_valid && (!req1_valid || last_grant);
        grant1      = req1_valid && (!req0_valid || !last_grant);
        timeout_hit = (tcnt == TLAST);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            ops_q      <= '0;
            cnt        <= '0;
            tcnt       <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant0 || grant1) begin
                    ops_q      <= grant1 ? req1_ops : req0_ops;
                    id_q       <= grant1;
                    last_grant <= grant1;
                end
                CLR:  cnt <= '0;
                SEND: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) tcnt <= '0;
                end
                WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    // A result arriving on the limit cycle still counts as success.
                    if (dp_valid) begin
                        data_q <= dp_result;
                        err_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (grant0 || grant1) state_nx = CLR;
            CLR:  state_nx = SEND;
            SEND: if (cnt == 2'd3) state_nx = WAIT;
            WAIT: if (dp_valid || timeout_hit) state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is high, even if the state register has not yet cleared.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        dp_capture = 1'b0;
        dp_op      = '0;
        dp_d_in    = '0;
        rsp_valid  = 1'b0;
        rsp_id     = 1'b0;
        rsp_data   = '0;
        rsp_err    = 1'b0;
        busy       = 1'b0;
        dp_reset   = reset || (state == CLR);
        if (!reset) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    req0_ready = grant0;
                    req1_ready = grant1;
                end
                SEND: begin
                    dp_capture = 1'b1;
                    dp_op      = cnt;
                    dp_d_in    = ops_q[int'(cnt)*WIDTH +: WIDTH];
                end
                RESP: begin
                    rsp_valid = 1'b1;
                    rsp_id    = id_q;
                    rsp_data  = data_q;
                    rsp_err   = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_job_scheduler.sv
// Scoreboard bench for dp_job_scheduler: random jobs from two requesters, a behavioural compute-unit model
// with programmable response latency, and a monitor that checks arbitration, latency and responses.
module tb_dp_job_scheduler;

    localparam int TIMEOUT = 15;

    typedef struct {
        int         id;
        logic [8:0] data;
        logic       err;
        int         lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_ops, req1_ops;
    logic        req0_ready, req1_ready;
    logic        dp_reset, dp_capture;
    logic [1:0]  dp_op;
    logic [7:0]  dp_d_in;
    logic        dp_valid;
    logic [8:0]  dp_result;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [8:0]  rsp_data;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   lat_cur [2];
    bit   bp_hold = 0;
    exp_t sb [$];
    int   grant_log [$];
    int   last_cap3 = -100;

    dp_job_scheduler #(.WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ops(req0_ops), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_ops(req1_ops), .req1_ready(req1_ready),
        .dp_reset(dp_reset), .dp_capture(dp_capture), .dp_op(dp_op), .dp_d_in(dp_d_in),
        .dp_valid(dp_valid), .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Unit behaviour: each difference wraps to 8 bits, the sum keeps its carry in 9 bits.
    function automatic logic [8:0] model_result(input logic [31:0] ops);
        int d1, d2;
        d1 = (int'(ops[7:0]) - int'(ops[15:8])) & 255;
        d2 = (int'(ops[23:16]) - int'(ops[31:24])) & 255;
        return 9'(d1 + d2);
    endfunction

    function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // 99 means the unit never answers; 15 answers one cycle too late.
    function automatic int rand_lat();
        int k;
        k = $urandom_range(0, 9);
        if (k < 7) return $urandom_range(0, 6);
        case (k)
            7:       return 14;
            8:       return 15;
            default: return 99;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic submit(input int r, input logic [31:0] ops, input int lat);
        int n;
        bit done;
        n = 0;
        done = 0;
        lat_cur[r] = lat;
        if (r == 0) begin req0_ops = ops; req0_valid = 1'b1; end
        else        begin req1_ops = ops; req1_valid = 1'b1; end
        while (!done && n < 400) begin
            @(negedge clock);
            done = (r == 0) ? req0_ready : req1_ready;
            n++;
        end
        chk("accept_timeout", 32'(done), 32'd1);
        @(posedge clock); #1;
        if (r == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || rsp_valid) && n < 600) begin
            @(negedge clock);
            n++;
        end
        chk("drain_timeout", 32'(n < 600), 32'd1);
        @(posedge clock); #1;
    endtask

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clock); #1;
            rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Compute-unit model: checks the operand stream and answers after the job's latency.
    int         u_seq = 0, u_prev_cap = -100, u_last_rst = -100, u_wcnt = 0, u_lat = 0;
    bit         u_pend = 0;
    logic [7:0] u_opv [4];
    logic [8:0] u_res;
    initial begin
        dp_valid  = 1'b0;
        dp_result = '0;
        forever begin
            @(negedge clock);
            dp_valid = 1'b0;
            if (dp_reset) begin
                u_seq = 0;
                u_pend = 0;
                u_last_rst = cyc;
            end else begin
                if (u_pend) begin
                    if (u_wcnt == 0) begin
                        dp_valid = 1'b1;
                        dp_result = u_res;
                        u_pend = 0;
                    end else u_wcnt--;
                end
                if (dp_capture) begin
                    chk("cap_op", 32'(dp_op), 32'(u_seq));
                    if (u_seq == 0) chk("clr_before_send", 32'(u_last_rst), 32'(cyc - 1));
                    else            chk("cap_consecutive", 32'(cyc), 32'(u_prev_cap + 1));
                    u_opv[dp_op] = dp_d_in;
                    u_prev_cap = cyc;
                    if (dp_op == 2'd3) begin
                        u_seq = 0;
                        last_cap3 = cyc;
                        u_res = model_result({u_opv[3], u_opv[2], u_opv[1], u_opv[0]});
                        u_lat = (sb.size() != 0) ? sb[0].lat : 99;
                        u_pend = (u_lat < 99);
                        u_wcnt = u_lat;
                    end else u_seq = int'(dp_op) + 1;
                end
            end
        end
    end

    // Monitor: arbitration model on grants, scoreboard compare on response handshakes.
    int          m_last = 1, m_gid, m_exp;
    bit          m_prev_valid = 0, m_prev_hs = 0;
    logic [10:0] m_prev_rsp;
    logic [31:0] m_ops;
    exp_t        m_e;
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                m_prev_valid = 0;
                m_prev_hs = 0;
                m_last = 1;
                sb.delete();
            end else begin
                if (req0_ready || req1_ready) begin
                    chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
                    chk("ready_only_idle", 32'(busy), 32'd0);
                    m_gid = req1_ready ? 1 : 0;
                    chk("ready_needs_valid", 32'(m_gid != 0 ? req1_valid : req0_valid), 32'd1);
                    m_exp = (req0_valid && req1_valid) ? 1 - m_last : (req1_valid ? 1 : 0);
                    chk("grant_rr", 32'(m_gid), 32'(m_exp));
                    m_last = m_gid;
                    grant_log.push_back(m_gid);
                    m_ops = (m_gid != 0) ? req1_ops : req0_ops;
                    m_e.id = m_gid;
                    m_e.lat = lat_cur[m_gid];
                    m_e.err = (m_e.lat >= TIMEOUT);
                    m_e.data = m_e.err ? 9'd0 : model_result(m_ops);
                    sb.push_back(m_e);
                end
                if (rsp_valid) begin
                    if (m_prev_valid && !m_prev_hs)
                        chk("rsp_stable", 32'({rsp_id, rsp_err, rsp_data}), 32'(m_prev_rsp));
                    else if (sb.size() == 0)
                        chk("rsp_spurious", 32'(rsp_valid), 32'd0);
                    else
                        chk("rsp_latency", 32'(cyc),
                            32'(last_cap3 + ((sb[0].lat >= TIMEOUT) ? TIMEOUT + 1 : sb[0].lat + 2)));
                    if (rsp_ready && sb.size() != 0) begin
                        m_e = sb.pop_front();
                        chk("rsp_id", 32'(rsp_id), 32'(m_e.id));
                        chk("rsp_data", 32'(rsp_data), 32'(m_e.data));
                        chk("rsp_err", 32'(rsp_err), 32'(m_e.err));
                    end
                end
                m_prev_valid = rsp_valid;
                m_prev_hs = rsp_valid && rsp_ready;
                m_prev_rsp = {rsp_id, rsp_err, rsp_data};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    int wait_n, gl_start;
    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_ops = '0; req1_ops = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_dp_reset", 32'(dp_reset), 32'd1);
        chk("rst_outputs", 32'({rsp_valid, rsp_id, rsp_err, busy, dp_capture, req0_ready, req1_ready}), 32'd0);
        chk("rst_data", 32'({rsp_data, dp_op, dp_d_in}), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_dp_reset", 32'(dp_reset), 32'd0);
        @(posedge clock); #1;

        // Directed operand patterns: plain, carry out, borrow wrap (answered on the limit cycle).
        submit(0, pack(10, 3, 20, 5), 2);
        submit(0, pack(200, 10, 250, 50), 0);
        submit(0, pack(3, 10, 0, 0), 14);
        drain();

        // Timeout with a held response; a waiting requester must not be granted meanwhile.
        bp_hold = 1;
        submit(0, pack(1, 2, 3, 4), 99);
        fork
            begin
                wait_n = 0;
                while (!rsp_valid && wait_n < 60) begin
                    @(negedge clock);
                    wait_n++;
                end
                chk("timeout_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("timeout_err", 32'(rsp_err), 32'd1);
                chk("timeout_data", 32'(rsp_data), 32'd0);
                repeat (5) begin
                    @(negedge clock);
                    chk("bp_valid_held", 32'(rsp_valid), 32'd1);
                    chk("bp_no_grant", 32'(req1_ready), 32'd0);
                end
                @(posedge clock); #1;
                bp_hold = 0;
            end
            begin
                repeat (3) begin @(posedge clock); #1; end
                submit(1, $urandom(), 1);
            end
        join
        drain();

        // Both requesters continuously valid.
        gl_start = grant_log.size();
        fork
            repeat (2) submit(0, $urandom(), $urandom_range(0, 6));
            repeat (2) submit(1, $urandom(), $urandom_range(0, 6));
        join
        drain();
        chk("grant_count", 32'(grant_log.size() - gl_start), 32'd4);
        for (int i = 0; i < 4 && gl_start + i < grant_log.size(); i++)
            chk("grant_order", 32'(grant_log[gl_start + i]), 32'(i % 2));

        // Random traffic.
        fork
            repeat (14) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                submit(0, $urandom(), rand_lat());
            end
            repeat (14) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                submit(1, $urandom(), rand_lat());
            end
        join
        drain();

        // Reset during the second capture cycle drops the job; a resubmission then completes.
        submit(0, pack(50, 20, 7, 1), 3);
        wait_n = 0;
        while (!(dp_capture && dp_op == 2'd0) && wait_n < 20) begin
            @(negedge clock);
            wait_n++;
        end
        chk("midrst_first_capture", 32'(dp_capture), 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_dp_reset", 32'(dp_reset), 32'd1);
        chk("midrst_outputs", 32'({rsp_valid, rsp_id, rsp_err, busy, dp_capture, req0_ready, req1_ready}), 32'd0);
        chk("midrst_data", 32'({rsp_data, dp_op, dp_d_in}), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_idle", 32'({busy, rsp_valid}), 32'd0);
        @(posedge clock); #1;
        submit(0, pack(50, 20, 7, 1), 3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dp_job_scheduler.md
Name: dp_job_scheduler

Overview:
- Shares one four-operand compute unit, result = (A-B)+(C-D), between two requesters.
- Each requester submits a complete job (A,B,C,D) through a valid/ready handshake; requesters are picked round-robin.
- For each granted job the block clears the unit, serializes the four operands onto its capture/op/d_in interface, waits for the unit's valid pulse (with timeout), and returns the (WIDTH+1)-bit result tagged with the requester id.
- Sits between the bus-side requesters and the compute unit.

Parameters:
- WIDTH, 8, operand width; result width is WIDTH+1.
- TIMEOUT, 15, maximum cycles spent in WAIT before the job is aborted with an error.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a job.
- req0_ops  input  4*WIDTH  requester 0 operands; A=[WIDTH-1:0], B next, C next, D=[4*WIDTH-1:3*WIDTH].
- req0_ready  output  1  job accepted this cycle.
- req1_valid, req1_ops, req1_ready  same as requester 0, for requester 1.
- dp_reset  output  1  active-high clear to the compute unit.
- dp_capture  output  1  operand capture strobe.
- dp_op  output  2  operand select: 0=A, 1=B, 2=C, 3=D.
- dp_d_in  output  WIDTH  operand value.
- dp_valid  input  1  unit result-ready pulse.
- dp_result  input  WIDTH+1  unit result.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  requester that owns the response.
- rsp_data  output  WIDTH+1  result value.
- rsp_err  output  1  job timed out.
- busy  output  1  high in every state except IDLE.

Behaviour:
- States: IDLE, CLR, SEND, WAIT, RESP.
- Reset: state=IDLE; last_grant=1, so requester 0 wins the first tie. Operand count=0, timeout count=0.
- Output values while reset is high or right after it: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, dp_capture=0, dp_op=0, dp_d_in=0, busy=0, req*_ready=0.
- dp_reset = reset OR (state==CLR). A mid-job reset therefore also clears the unit; the job is dropped and no response is produced.
- IDLE, no request: nothing happens.
- IDLE, one req_valid: that requester is granted.
- IDLE, both req_valid: the requester not equal to last_grant is granted.
- On grant, the granted reqN_ready=1 combinationally in the same cycle. At the clock edge: latch the operands and id, set last_grant=id, go to CLR. The other ready stays 0.
- req*_ready is never asserted outside IDLE. Requests arriving while busy wait; they are not queued internally.
- CLR: one cycle with dp_reset=1, then SEND with count=0.
- SEND: four consecutive cycles with dp_capture=1, dp_op=count, dp_d_in=latched operand[count]. After count==3, go to WAIT with the timeout count cleared. dp_capture=0 in all other states.
- WAIT: the timeout count increments every cycle.
  - dp_valid=1: register rsp_data=dp_result, rsp_err=0, go to RESP.
  - Else if count==TIMEOUT-1: rsp_data=0, rsp_err=1, go to RESP.
  - dp_valid on the same cycle the limit is reached: dp_valid wins.
  - dp_valid outside WAIT is ignored.
- RESP: rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1. On that handshake, go to IDLE at the next edge. A new grant is possible the cycle after the handshake, not in the same cycle.
- Latency: job accepted at edge T → CLR cycle T+1 → SEND cycles T+2..T+5 → WAIT from T+6 → rsp_valid the cycle after dp_valid.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- Arithmetic: none in this block; dp_result is passed through unmodified (9 bits for WIDTH=8).

Test Plan:
- Single job: req0_ops A=10,B=3,C=20,D=5; unit model returns (A-B)+(C-D) → dp_op sequence 0,1,2,3 on four consecutive capture cycles after one dp_reset cycle; rsp_valid with rsp_id=0, rsp_data=9'd22, rsp_err=0.
- Carry out: A=200,B=10,C=250,D=50 → rsp_data=9'h186 (390).
- Borrow wrap: A=3,B=10,C=0,D=0 → rsp_data=9'd249, rsp_err=0.
- Arbitration: both requesters valid continuously for 4 jobs → grant order 0,1,0,1; ready pulses exactly one cycle each and are never both high.
- Timeout and backpressure: unit model never asserts dp_valid → after 15 WAIT cycles rsp_err=1, rsp_data=0; hold rsp_ready=0 for 5 cycles → rsp_* stable, no new grant; rsp_ready=1 → IDLE.
- Reset mid-SEND: assert reset at the second capture cycle → dp_reset=1, all outputs 0, state IDLE, no rsp_valid; a resubmitted job completes correctly.
